stage_id: RTL
=============

Name: stage_id

Overview:
- Instruction Decode stage of the 5-stage pipelined CPU.
- Sits directly downstream of the instruction-fetch stage and consumes its registered PC+4 and instruction.
- Decodes a MIPS subset, reads the 32x32 register file (written back from WB), and detects load-use hazards and MEM-stage redirects.
- Drives the ID/EX pipeline register feeding EX.

Parameters:
- NREG, 32, number of architectural registers (index width 5; register 0 hardwired to zero)
- NOP_CTRL, 10'd0, control bundle value used for bubbles

Ports:
- Clk  input  1  clock, all state updates on rising edge
- Clr  input  1  synchronous reset, active-high
- IFout_PC4  input  32  PC+4 of the instruction in decode
- IFout_Inst  input  32  instruction in decode
- MEM_PCSrc  input  1  branch/jump taken in MEM; flush request
- WB_RegWrite  input  1  register-file write enable from WB
- WB_Rd  input  5  write-back destination register
- WB_Data  input  32  write-back data
- ID_Stall  output  1  combinational; upstream holds PC and IFout_* stable while 1
- IDout_PC4  output  32  registered PC+4
- IDout_RsData  output  32  registered rs read data
- IDout_RtData  output  32  registered rt read data
- IDout_Imm  output  32  registered sign-extended inst[15:0]
- IDout_Jtarg  output  32  registered {PC4[31:28], inst[25:0], 2'b00}
- IDout_Rs, IDout_Rt, IDout_Rd  output  5 each  registered register indices
- IDout_Funct  output  6  registered inst[5:0]
- IDout_Ctrl  output  10  registered control: [0]RegWrite [1]MemtoReg [2]MemWrite [3]MemRead [4]Branch [5]Jump [6]ALUSrc [7]RegDst [9:8]ALUOp

Behaviour:
- Reset (Clr=1 at an edge): all IDout_* go to 0 and all 32 registers clear to 0. ID_Stall is 0 when IDout_Ctrl[3]=0.
- Reset mid-operation discards any pending stall or flush; the first post-reset edge decodes the current IFout_Inst.
- Decode by opcode inst[31:26], written as Ctrl bits [9:0]:
  - 000000 R-type: 1010000001 (RegDst, ALUOp=10, RegWrite)
  - 100011 lw: 0001001011
  - 101011 sw: 0001000100
  - 000100 beq: 0100010000 (ALUOp=01)
  - 001000 addi: 0001000001
  - 000010 j: 0000100000
  - any other opcode: NOP_CTRL
- Register file:
  - Write on rising edge when WB_RegWrite=1 and WB_Rd!=0; writes to register 0 are ignored.
  - Reads are combinational. If WB_RegWrite=1 and WB_Rd equals the read index (nonzero), the read returns WB_Data in the same cycle.
- Load-use hazard: ID_Stall=1 when all of the following hold:
  - IDout_Ctrl[3]=1
  - IDout_Rt!=0
  - IDout_Rt equals inst[25:21], or equals inst[20:16] and the opcode is R-type, sw or beq
- Latency: one cycle. Decode of IFout_Inst at edge n appears on IDout_* after edge n.
- Priority at each edge: Clr > MEM_PCSrc > ID_Stall > normal.
  - MEM_PCSrc=1: load a bubble (IDout_Ctrl=NOP_CTRL, all other IDout_* to 0). The instruction in decode is squashed. ID_Stall is ignored.
  - ID_Stall=1 (no flush): load a bubble. The decoded instruction reappears next cycle because upstream holds it. The stall lasts exactly one cycle, since the bubble clears IDout_Ctrl[3].
  - Normal: load all decoded fields.
- Bubble and flush never suppress the WB register-file write.
- Widths: Imm is inst[15] replicated 16 times concatenated with inst[15:0]. Jtarg wraps within the 256 MB region given by PC4[31:28].

Test Plan:
- Reset: Clr=1 for 2 cycles with WB_RegWrite=1, WB_Rd=5 -> all IDout_*=0, register 5 stays 0, ID_Stall=0.
- Write/bypass: WB writes 0x12345678 to r8 while IFout_Inst=add r3,r8,r9 (0x01091820) -> IDout_RsData=0x12345678 after the edge, IDout_Ctrl=10'b1010000001, IDout_Rd=3.
- Zero register: WB writes 0xFFFFFFFF to r0, then decode of addi r1,r0,-4 (0x2001FFFC) -> IDout_RsData=0, IDout_Imm=0xFFFFFFFC, IDout_Ctrl=10'b0001000001.
- Load-use: lw r2,0(r1) (0x8C220000) followed by add r4,r2,r3 (0x00432020):
  - ID_Stall=1 for exactly one cycle and IDout_Ctrl=0 for that cycle.
  - On the next cycle the add decodes with IDout_Rs=2.
- Flush: MEM_PCSrc=1 while decoding j 0x0040000 (0x08040000), and also with a stall pending -> IDout_Ctrl=0 and IDout_Jtarg=0 next cycle, flush wins.
- Jump target: IFout_PC4=0x30000010, inst=0x0BFFFFFF with no flush -> IDout_Jtarg=0x3FFFFFFC, IDout_Ctrl[5]=1.

Source files
------------

// File: rtl/stage_id.sv
// Instruction decode stage: decodes a MIPS subset, reads the register file, detects load-use and redirect hazards.
// Latency: one cycle from IFout_* to IDout_*; ID_Stall is combinational from the current ID/EX contents.
// Backpressure: ID_Stall asks upstream to hold PC and IFout_* for one cycle while a bubble is inserted.
module stage_id #(
  parameter int         NREG     = 32,
  parameter logic [9:0] NOP_CTRL = 10'd0
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [31:0] IFout_PC4,
  input  logic [31:0] IFout_Inst,
  input  logic        MEM_PCSrc,
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_Rd,
  input  logic [31:0] WB_Data,
  output logic        ID_Stall,
  output logic [31:0] IDout_PC4,
  output logic [31:0] IDout_RsData,
  output logic [31:0] IDout_RtData,
  output logic [31:0] IDout_Imm,
  output logic [31:0] IDout_Jtarg,
  output logic [4:0]  IDout_Rs,
  output logic [4:0]  IDout_Rt,
  output logic [4:0]  IDout_Rd,
  output logic [5:0]  IDout_Funct,
  output logic [9:0]  IDout_Ctrl
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [31:0] regs [NREG];

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm;
  logic [31:0] jtarg;
  logic [9:0]  ctrl;
  logic        uses_rt;

  assign opcode = IFout_Inst[31:26];
  assign rs     = IFout_Inst[25:21];
  assign rt     = IFout_Inst[20:16];
  assign rd     = IFout_Inst[15:11];
  assign imm    = {{16{IFout_Inst[15]}}, IFout_Inst[15:0]};
  assign jtarg  = {IFout_PC4[31:28], IFout_Inst[25:0], 2'b00};

  // Register 0 reads as zero; a same-cycle WB write to the read index is forwarded.
  assign rs_data = (rs == 5'd0) ? 32'd0 :
                   (WB_RegWrite && (WB_Rd == rs)) ? WB_Data : regs[rs];
  assign rt_data = (rt == 5'd0) ? 32'd0 :
                   (WB_RegWrite && (WB_Rd == rt)) ? WB_Data : regs[rt];

  // Control bundle per opcode; unknown opcodes decode as a bubble.
  always_comb begin
    ctrl    = NOP_CTRL;
    uses_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin ctrl = 10'b1010000001; uses_rt = 1'b1; end
      OP_LW:    ctrl = 10'b0001001011;
      OP_SW:    begin ctrl = 10'b0001000100; uses_rt = 1'b1; end
      OP_BEQ:   begin ctrl = 10'b0100010000; uses_rt = 1'b1; end
      OP_ADDI:  ctrl = 10'b0001000001;
      OP_J:     ctrl = 10'b0000100000;
      default:  ctrl = NOP_CTRL;
    endcase
  end

  // A load in EX whose destination is a source of the instruction in decode.
  assign ID_Stall = IDout_Ctrl[3] && (IDout_Rt != 5'd0) &&
                    ((IDout_Rt == rs) || ((IDout_Rt == rt) && uses_rt));

  // Register file: reset clears everything, register 0 is never written.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      for (int i = 0; i < NREG; i++) regs[i] <= 32'd0;
    end else if (WB_RegWrite && (WB_Rd != 5'd0)) begin
      regs[WB_Rd] <= WB_Data;
    end
  end

  // ID/EX register: reset, then flush, then stall bubble, else decoded fields.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      IDout_PC4    <= 32'd0;
      IDout_RsData <= 32'd0;
      IDout_RtData <= 32'd0;
      IDout_Imm    <= 32'd0;
      IDout_Jtarg  <= 32'd0;
      IDout_Rs     <= 5'd0;
      IDout_Rt     <= 5'd0;
      IDout_Rd     <= 5'd0;
      IDout_Funct  <= 6'd0;
      IDout_Ctrl   <= 10'd0;
    end else if (MEM_PCSrc || ID_Stall) begin
      IDout_PC4    <= 32'd0;
      IDout_RsData <= 32'd0;
      IDout_RtData <= 32'd0;
      IDout_Imm    <= 32'd0;
      IDout_Jtarg  <= 32'd0;
      IDout_Rs     <= 5'd0;
      IDout_Rt     <= 5'd0;
      IDout_Rd     <= 5'd0;
      IDout_Funct  <= 6'd0;
      IDout_Ctrl   <= NOP_CTRL;
    end else begin
      IDout_PC4    <= IFout_PC4;
      IDout_RsData <= rs_data;
      IDout_RtData <= rt_data;
      IDout_Imm    <= imm;
      IDout_Jtarg  <= jtarg;
      IDout_Rs     <= rs;
      IDout_Rt     <= rt;
      IDout_Rd     <= rd;
      IDout_Funct  <= IFout_Inst[5:0];
      IDout_Ctrl   <= ctrl;
    end
  end

endmodule
